// File: rtl/ifns_pkg.sv
// Shared IFNS 6-bit/8-wire constants: the codebook and the forbidden-pattern test.
// The codebook lists the first 64 forbidden-pattern-free 8-bit words in ascending order, so ENC(0) = 8'h00.
package ifns_pkg;

  localparam int IFNS_DATA_W = 6;
  localparam int IFNS_CODE_W = 8;
  localparam int IFNS_WORDS  = 1 << IFNS_DATA_W;

  localparam logic [IFNS_CODE_W-1:0] IFNS_CODEBOOK_8 [0:IFNS_WORDS-1] = '{
    8'h00, 8'h01, 8'h03, 8'h06, 8'h07, 8'h0C, 8'h0E, 8'h0F,
    8'h18, 8'h19, 8'h1C, 8'h1E, 8'h1F, 8'h30, 8'h31, 8'h33,
    8'h38, 8'h39, 8'h3C, 8'h3E, 8'h3F, 8'h60, 8'h61, 8'h63,
    8'h66, 8'h67, 8'h70, 8'h71, 8'h73, 8'h78, 8'h79, 8'h7C,
    8'h7E, 8'h7F, 8'h80, 8'h81, 8'h83, 8'h86, 8'h87, 8'h8C,
    8'h8E, 8'h8F, 8'h98, 8'h99, 8'h9C, 8'h9E, 8'h9F, 8'hC0,
    8'hC1, 8'hC3, 8'hC6, 8'hC7, 8'hCC, 8'hCE, 8'hCF, 8'hE0,
    8'hE1, 8'hE3, 8'hE6, 8'hE7, 8'hF0, 8'hF1, 8'hF3, 8'hF8
  };

  // An interior wire that differs from both neighbours is a 010 or 101 pattern.
  function automatic logic ifns_fpf_ok(input logic [IFNS_CODE_W-1:0] code);
    logic ok;
    ok = 1'b1;
    for (int i = 1; i < IFNS_CODE_W - 1; i++) begin
      if ((code[i] != code[i-1]) && (code[i] != code[i+1])) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/ifns_encoder_8_if.sv
// Input word stream and output codeword stream of the IFNS 8-wire encoder.
// master is the side feeding words and accepting codewords; slave is the encoder.
interface ifns_encoder_8_if;
  import ifns_pkg::*;

  logic [IFNS_DATA_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [IFNS_CODE_W-1:0] codeout;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, codeout, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, codeout, out_valid
  );

endinterface

// File: rtl/decoderIFNS_6di_core.sv
// Combinational IFNS decode: reverse codebook lookup of an 8-wire codeword.
// hit is low for words outside the codebook; data is then 0.
module decoderIFNS_6di_core
  import ifns_pkg::*;
(
  input  logic [IFNS_CODE_W-1:0] code,
  output logic [IFNS_DATA_W-1:0] data,
  output logic                   hit
);

  always_comb begin
    data = '0;
    hit  = 1'b0;
    for (int i = 0; i < IFNS_WORDS; i++) begin
      if (code == IFNS_CODEBOOK_8[i]) begin
        data = i[IFNS_DATA_W-1:0];
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoderIFNS_6di_core.sv
// Combinational IFNS encode: 6-bit data word to its 8-wire codeword.
// Pure codebook lookup, no state.
module encoderIFNS_6di_core
  import ifns_pkg::*;
(
  input  logic [IFNS_DATA_W-1:0] data,
  output logic [IFNS_CODE_W-1:0] code
);

  assign code = IFNS_CODEBOOK_8[data];

endmodule

// File: rtl/ifns_encoder_8.sv
// IFNS 8-wire transmitter: S1 input register, S2 codeword register, 2 cycles from accept to codeout.
// A stalled output freezes S2 and S1; codeout only changes on an S2 load, so idle leaves the bus quiet.
module ifns_encoder_8
  import ifns_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst,
  ifns_encoder_8_if.slave  bus,
  output logic [CNT_W-1:0] tx_count,
  output logic             check_err
);

  logic                   s1_valid_q, s1_valid_d;
  logic [IFNS_DATA_W-1:0] s1_data_q, s1_data_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [IFNS_CODE_W-1:0] code_q, code_d;
  logic [IFNS_DATA_W-1:0] s2_src_q, s2_src_d;
  logic [CNT_W-1:0]       tx_count_q, tx_count_d;
  logic                   check_err_q, check_err_d;

  logic [IFNS_CODE_W-1:0] enc_code;
  logic [IFNS_DATA_W-1:0] dec_data;
  logic                   dec_hit;
  logic                   s1_adv;
  logic                   in_ready_c;
  logic                   in_xfer;
  logic                   out_xfer;

  encoderIFNS_6di_core u_enc (
    .data (s1_data_q),
    .code (enc_code)
  );

  decoderIFNS_6di_core u_dec (
    .code (code_q),
    .data (dec_data),
    .hit  (dec_hit)
  );

  // S1 may move into S2 whenever S2 is empty or is being emptied this cycle.
  assign s1_adv     = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign in_ready_c = !rst && (!s1_valid_q || s1_adv);
  assign in_xfer    = bus.in_valid && in_ready_c;
  assign out_xfer   = s2_valid_q && bus.out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_data_d  = bus.in_data;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    code_d     = code_q;
    s2_src_d   = s2_src_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      code_d     = enc_code;
      s2_src_d   = s1_data_q;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

    tx_count_d  = tx_count_q + {{(CNT_W-1){1'b0}}, out_xfer};
    // A codeword outside the codebook counts as a decode mismatch too.
    check_err_d = check_err_q || (s2_valid_q && (!dec_hit || (dec_data != s2_src_q)));
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      code_q      <= '0;
      s2_src_q    <= '0;
      tx_count_q  <= '0;
      check_err_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      code_q      <= code_d;
      s2_src_q    <= s2_src_d;
      tx_count_q  <= tx_count_d;
      check_err_q <= check_err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.codeout   = code_q;
  assign bus.out_valid = s2_valid_q;
  assign tx_count      = tx_count_q;
  assign check_err     = check_err_q;

endmodule

// File: tb/tb_ifns_encoder_8.sv
// Directed and random bench for ifns_encoder_8 with a data scoreboard.
// Expected codewords: the n-th forbidden-pattern-free 8-bit word in ascending order.
module tb_ifns_encoder_8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ifns_encoder_8_if bus ();
  ifns_encoder_8_if bus4 ();

  logic [15:0] tx_count;
  logic        check_err;
  logic [3:0]  tx_count4;
  logic        check_err4;

  assign bus4.in_data   = bus.in_data;
  assign bus4.in_valid  = bus.in_valid;
  assign bus4.out_ready = bus.out_ready;

  ifns_encoder_8 #(.CNT_W(16)) dut (
    .clock     (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .tx_count  (tx_count),
    .check_err (check_err)
  );

  ifns_encoder_8 #(.CNT_W(4)) dut4 (
    .clock     (clk),
    .rst       (rst),
    .bus       (bus4.slave),
    .tx_count  (tx_count4),
    .check_err (check_err4)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  int          tick_n = 0;
  int          first_acc = -1;
  int          first_out = -1;
  int          last_out = -1;
  bit          sb_on = 1'b1;
  int unsigned sb[$];
  logic [7:0]  exp_code [0:63];

  function automatic bit tb_fpf(input logic [7:0] c);
    for (int i = 1; i < 7; i++) begin
      if ((c[i] != c[i-1]) && (c[i] != c[i+1])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Entered just after a falling edge; returns just after the next falling edge.
  task automatic tick(input logic iv, input logic [5:0] id, input logic ordy, output bit acc);
    int unsigned d;
    check("tx_count", tx_count, n_out % 65536);
    check("tx_count4", tx_count4, n_out % 16);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (sb_on) begin
        check("sb_has_word", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          d = sb.pop_front();
          check("codeout", bus.codeout, exp_code[d]);
          check("codeout_fpf", tb_fpf(bus.codeout), 1);
        end
      end
      n_out++;
      if (first_out < 0) first_out = tick_n;
      last_out = tick_n;
    end
    if (acc) begin
      if (first_acc < 0) first_acc = tick_n;
      if (sb_on) sb.push_back(32'(id));
    end
    tick_n++;
    @(negedge clk);
  endtask

  task automatic send(input logic [5:0] d, input logic ordy);
    bit a;
    int n;
    n = 0;
    a = 1'b0;
    while (!a && n < 200) begin
      tick(1'b1, d, ordy, a);
      n++;
    end
    check("send_accept", a, 1);
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
      tick(1'b0, 6'd0, 1'b1, a);
      n++;
    end
    check("drain_sb_empty", sb.size(), 0);
    check("drain_idle", bus.out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         a;
    int         n;
    int         sent;
    int         budget;
    int         out0;
    logic [7:0] cc;

    n = 0;
    for (int c = 0; c < 256; c++) begin
      cc = c[7:0];
      if (tb_fpf(cc) && n < 64) begin
        exp_code[n] = cc;
        n++;
      end
    end

    // Reset, then idle
    bus.in_valid  = 1'b0;
    bus.in_data   = 6'd0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_codeout", bus.codeout, 8'h00);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_check_err", check_err, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    n_out = 0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);

    // Exhaustive back-to-back stream
    for (int v = 0; v < 64; v++) begin
      tick(1'b1, v[5:0], 1'b1, a);
      check("exh_accept", a, 1);
    end
    drain();
    check("exh_latency", first_out - first_acc, 2);
    check("exh_contiguous", last_out - first_out, 63);
    check("exh_tx_count", tx_count, 64);
    check("exh_tx_count4_wrap", tx_count4, 0);
    check("exh_check_err", check_err, 0);

    // Stall with out_ready low
    send(6'h15, 1'b0);
    send(6'h2A, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 6'h3F, 1'b0, a);
      check("stall_no_accept", a, 0);
      check("stall_codeout", bus.codeout, exp_code[6'h15]);
      check("stall_out_valid", bus.out_valid, 1);
    end
    out0 = n_out;
    send(6'h3F, 1'b1);
    drain();
    check("stall_release_count", n_out - out0, 3);

    // Idle hold
    send(6'h3F, 1'b1);
    drain();
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 6'd0, 1'b1, a);
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_codeout", bus.codeout, exp_code[6'h3F]);
    end

    // Random valid/ready
    out0 = n_out;
    sent = 0;
    budget = 0;
    while (sent < 10000 && budget < 60000) begin
      tick($urandom_range(0, 1) == 1, 6'($urandom_range(0, 63)), $urandom_range(0, 9) < 3, a);
      if (a) sent++;
      budget++;
    end
    check("rand_sent", sent, 10000);
    drain();
    check("rand_delivered", n_out - out0, 10000);
    check("rand_check_err", check_err, 0);

    // Reset with both stages full
    tick(1'b1, 6'h11, 1'b0, a);
    tick(1'b1, 6'h22, 1'b0, a);
    check("full_out_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_codeout", bus.codeout, 8'h00);
    check("midrst_tx_count", tx_count, 0);
    rst = 1'b0;
    sb.delete();
    n_out = 0;
    send(6'h07, 1'b1);
    send(6'h08, 1'b1);
    drain();
    check("midrst_post_count", n_out, 2);

    // Corrupted encode -> sticky self-check error
    sb_on = 1'b0;
    force dut.enc_code = 8'hFF;
    send(6'h05, 1'b1);
    repeat (4) tick(1'b0, 6'd0, 1'b1, a);
    release dut.enc_code;
    check("corrupt_check_err", check_err, 1);
    check("clean_check_err4", check_err4, 0);
    sb_on = 1'b1;
    send(6'h09, 1'b1);
    drain();
    check("sticky_check_err", check_err, 1);
    rst = 1'b1;
    @(negedge clk);
    check("final_rst_check_err", check_err, 0);
    check("final_rst_tx_count", tx_count, 0);
    rst = 1'b0;
    n_out = 0;
    send(6'h2B, 1'b1);
    drain();
    check("final_check_err", check_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
